channel_sequencer: RTL and testbench

CHANNEL_SEQUENCER -- requirements
Module: channel_sequencer

---
 rtl/channel_seq_pkg.sv | 22 ++
 rtl/channel_arbiter.sv | 47 ++++
 rtl/channel_sequencer.sv | 111 +++++++++++
 tb/tb_channel_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/channel_seq_pkg.sv
// Shared definitions for the channel sequencer: channel count, mux select
// encodings, FSM state type and small channel-index helpers.
package channel_seq_pkg;

    localparam int NUM_CH = 3;

    localparam logic [1:0] SEL_ALPHA = 2'd0;
    localparam logic [1:0] SEL_BETA  = 2'd1;
    localparam logic [1:0] SEL_GAMMA = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_HOLD   = 2'd2
    } seq_state_e;

    // Channel after ch in round-robin order, wrapping gamma back to alpha.
    function automatic logic [1:0] next_chan(input logic [1:0] ch);
        return (ch == SEL_GAMMA) ? SEL_ALPHA : ch + 2'd1;
    endfunction

endpackage

// File: rtl/channel_arbiter.sv
// Combinational winner selection among the three request lines.
// CHANNEL_SEQUENCER_RR_EN defined: round-robin starting at ptr.
// Undefined: fixed priority alpha > beta > gamma, no pointer input.
module channel_arbiter
    import channel_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
`ifdef CHANNEL_SEQUENCER_RR_EN
    input  logic [1:0]        ptr,
`endif
    output logic [1:0]        winner,
    output logic              any_req
);

    assign any_req = |req;

`ifdef CHANNEL_SEQUENCER_RR_EN
    // Walk the channels starting at ptr; first requester found wins.
    always_comb begin
        logic       found;
        logic [1:0] ch;
        winner = SEL_ALPHA;
        found  = 1'b0;
        ch     = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[ch]) begin
                winner = ch;
                found  = 1'b1;
            end
            ch = next_chan(ch);
        end
    end
`else
    // Fixed priority: lowest channel index wins.
    always_comb begin
        winner = SEL_ALPHA;
        if (req[0]) begin
            winner = SEL_ALPHA;
        end else if (req[1]) begin
            winner = SEL_BETA;
        end else if (req[2]) begin
            winner = SEL_GAMMA;
        end
    end
`endif

endmodule

// File: rtl/channel_sequencer.sv
// Three-channel sequencer: arbitrates requests, drives a downstream mux for
// one SELECT cycle, captures the returned word and holds it until consumed.
// Optional round-robin arbitration enabled by CHANNEL_SEQUENCER_RR_EN.
module channel_sequencer
    import channel_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    req,
    output logic [NUM_CH-1:0]    ack,
    output logic [1:0]           sel,
    output logic                 cs,
    input  logic [WIDTH-1:0]     mux_data,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    seq_state_e       state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       winner;
    logic             any_req;

`ifdef CHANNEL_SEQUENCER_RR_EN
    // Pointer holds the channel where the next search starts.
    logic [1:0]       ptr_q, ptr_d;
`endif

    channel_arbiter u_arbiter (
        .req     (req),
`ifdef CHANNEL_SEQUENCER_RR_EN
        .ptr     (ptr_q),
`endif
        .winner  (winner),
        .any_req (any_req)
    );

    // State, grant, captured word (and search pointer) registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= SEL_ALPHA;
            out_data_q <= '0;
`ifdef CHANNEL_SEQUENCER_RR_EN
            ptr_q      <= SEL_ALPHA;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            out_data_q <= out_data_d;
`ifdef CHANNEL_SEQUENCER_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Next-state: arbitration happens in IDLE, or in HOLD when the word is taken.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        out_data_d = out_data_q;
`ifdef CHANNEL_SEQUENCER_RR_EN
        ptr_d      = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                // Capture on the latched grant even if its request has dropped.
                out_data_d = mux_data;
                state_d    = ST_HOLD;
`ifdef CHANNEL_SEQUENCER_RR_EN
                ptr_d      = next_chan(grant_q);
`endif
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (any_req) begin
                        grant_d = winner;
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cs        = (state_q == ST_SELECT);
    assign sel       = cs ? grant_q : SEL_ALPHA;
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;

    // One-hot grant pulse, only during SELECT.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ack
            assign ack[gi] = cs && (grant_q == 2'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_channel_sequencer.sv
// Directed self-checking bench for channel_sequencer with a per-cycle
// protocol monitor on sel/cs/ack.
module tb_channel_sequencer;

    logic       clk;
    logic       reset;
    logic [2:0] req;
    logic [2:0] ack;
    logic [1:0] sel;
    logic       cs;
    logic [7:0] mux_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int tests_run = 0;
    int tests_failed = 0;
    logic cs_prev = 1'b0;

    channel_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .sel       (sel),
        .cs        (cs),
        .mux_data  (mux_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor: sel range, no back-to-back cs, ack consistent with sel.
    always @(negedge clk) begin
        if (!reset) begin
            if (sel == 2'd3) check_eq("mon_sel_range", 32'(sel), 32'd0);
            if (cs && cs_prev) check_eq("mon_cs_consec", 32'(cs_prev), 32'd0);
            if ((ack & (ack - 3'd1)) != 3'd0) check_eq("mon_ack_onehot", 32'(ack), 32'd0);
            if (cs && (ack != (3'b001 << sel))) check_eq("mon_ack_sel", 32'(ack), 32'(3'b001 << sel));
            if (!cs && (ack != 3'd0 || sel != 2'd0)) check_eq("mon_idle_outs", {27'd0, ack, sel}, 32'd0);
        end
        cs_prev <= cs;
    end

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [1:0] exp_sel [4];

    initial begin
        reset     = 1'b1;
        req       = 3'b000;
        mux_data  = 8'h00;
        out_ready = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_cs", 32'(cs), 32'd0);
        check_eq("rst_sel", 32'(sel), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);

        // Basic latency: req alpha, data A5
        req = 3'b001; mux_data = 8'hA5; out_ready = 1'b1;
        tick();
        check_eq("lat_cs", 32'(cs), 32'd1);
        check_eq("lat_sel", 32'(sel), 32'd0);
        check_eq("lat_ack", 32'(ack), 32'b001);
        check_eq("lat_valid_early", 32'(out_valid), 32'd0);
        req = 3'b000;
        tick();
        check_eq("lat_valid", 32'(out_valid), 32'd1);
        check_eq("lat_data", 32'(out_data), 32'hA5);
        check_eq("lat_cs_off", 32'(cs), 32'd0);
        tick();
        check_eq("lat_idle_valid", 32'(out_valid), 32'd0);

        // out_ready while idle has no effect
        out_ready = 1'b1;
        tick();
        check_eq("idle_ready_valid", 32'(out_valid), 32'd0);
        check_eq("idle_ready_cs", 32'(cs), 32'd0);

        // Hold stability with out_ready low and changing mux data
        out_ready = 1'b0; req = 3'b001; mux_data = 8'h3C;
        tick();
        check_eq("hold_sel_cs", 32'(cs), 32'd1);
        req = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            mux_data = 8'(8'h50 + i * 8'h11);
            check_eq("hold_data", 32'(out_data), 32'h3C);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_cs", 32'(cs), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("hold_release", 32'(out_valid), 32'd0);

        // Single-cycle gamma request still captured on latched grant
        out_ready = 1'b0; req = 3'b100; mux_data = 8'h77;
        tick();
        req = 3'b000;
        check_eq("gamma_cs", 32'(cs), 32'd1);
        check_eq("gamma_sel", 32'(sel), 32'd2);
        check_eq("gamma_ack", 32'(ack), 32'b100);
        tick();
        check_eq("gamma_valid", 32'(out_valid), 32'd1);
        check_eq("gamma_data", 32'(out_data), 32'h77);
        tick();
        check_eq("gamma_wait", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check_eq("gamma_idle", 32'(out_valid), 32'd0);
        check_eq("gamma_idle_cs", 32'(cs), 32'd0);

        // Back-to-back with all requests held
`ifdef CHANNEL_SEQUENCER_RR_EN
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd1; exp_sel[2] = 2'd2; exp_sel[3] = 2'd0;
`else
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd0; exp_sel[2] = 2'd0; exp_sel[3] = 2'd0;
`endif
        do_reset();
        req = 3'b111; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("b2b_cs", 32'(cs), 32'd1);
            check_eq("b2b_sel", 32'(sel), 32'(exp_sel[i]));
            mux_data = 8'(8'h10 + i);
            tick();
            check_eq("b2b_valid", 32'(out_valid), 32'd1);
            check_eq("b2b_data", 32'(out_data), 32'(8'h10 + i));
        end

        // Reset during HOLD discards the word and rewinds the pointer
        out_ready = 1'b0;
        tick();
        tick();
        check_eq("rsthold_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("rsthold_valid", 32'(out_valid), 32'd0);
        check_eq("rsthold_data", 32'(out_data), 32'd0);
        check_eq("rsthold_cs", 32'(cs), 32'd0);
        check_eq("rsthold_ack", 32'(ack), 32'd0);
        reset = 1'b0;
        req = 3'b111;
        tick();
        check_eq("rsthold_next_cs", 32'(cs), 32'd1);
        check_eq("rsthold_next_sel", 32'(sel), 32'd0);

        // Reset during SELECT: no word appears
        reset = 1'b1;
        tick();
        check_eq("rstsel_cs", 32'(cs), 32'd0);
        check_eq("rstsel_valid", 32'(out_valid), 32'd0);
        reset = 1'b0; req = 3'b000;
        tick();
        check_eq("rstsel_after_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
